// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and memory port, with memory-ready timeout and sticky fault flags.
module riscv_multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       s_rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic       retire,
   output logic       illegal,
   output logic       bus_err
);

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
   } state_e;

   state_e           state_q, state_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             funct_ok;
   logic [2:0]       alu_dec;
   logic             timeout_hit;

   always_comb begin
      funct_ok = funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
      case (funct3)
         3'b000:  alu_dec = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_dec = ALU_SLT;
         3'b110:  alu_dec = ALU_OR;
         3'b111:  alu_dec = ALU_AND;
         default: alu_dec = ALU_ADD;
      endcase
   end

   // cnt_q counts wait cycles already spent; this cycle would be wait number cnt_q+1.
   assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (int'(cnt_q) == MEM_TIMEOUT - 1);

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
      state_d     = state_q;
      illegal_d   = illegal_q;
      bus_err_d   = bus_err_q;
      cnt_d       = '0;
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      imm_src     = 2'b00;
      alu_control = ALU_ADD;
      retire      = 1'b0;

      case (state_q)
         S_FETCH: begin
            ir_write   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            pc_write   = 1'b1;
            state_d    = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = 2'b10;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = funct_ok ? S_EXECR : S_TRAP;
               OP_I:         state_d = funct_ok ? S_EXECI : S_TRAP;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_TRAP;
            endcase
            if (state_d == S_TRAP) illegal_d = 1'b1;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            imm_src   = (opcode == OP_SW) ? 2'b01 : 2'b00;
            state_d   = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD, S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = (state_q == S_MEMWRITE);
            cnt_d     = cnt_q + 1'b1;
            if (mem_ready) begin
               retire  = (state_q == S_MEMWRITE);
               state_d = (state_q == S_MEMWRITE) ? S_FETCH : S_MEMWB;
            end else if (timeout_hit) begin
               state_d   = S_TRAP;
               bus_err_d = 1'b1;
            end
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a   = 2'b10;
            alu_control = alu_dec;
            state_d     = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = alu_dec;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a   = 2'b10;
            alu_control = ALU_SUB;
            pc_write    = zero;
            retire      = 1'b1;
            state_d     = S_FETCH;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            state_d   = S_ALUWB;
         end
         default: state_d = S_TRAP;
      endcase

      // While reset is held, the datapath must see no enables at all.
      if (s_rst) begin
         pc_write    = 1'b0;
         adr_src     = 1'b0;
         ir_write    = 1'b0;
         mem_write   = 1'b0;
         reg_write   = 1'b0;
         result_src  = 2'b00;
         alu_src_a   = 2'b00;
         alu_src_b   = 2'b00;
         imm_src     = 2'b00;
         alu_control = ALU_ADD;
         retire      = 1'b0;
      end
   end

   assign illegal = illegal_q && !s_rst;
   assign bus_err = bus_err_q && !s_rst;

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (s_rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
- Control FSM that sequences a multicycle RV32I datapath sharing one ALU and one memory port across fetch, decode, execute, memory and writeback phases.
- Decodes opcode, funct3 and funct7[5] from the instruction register and drives every mux select and write enable of the datapath each cycle.
- Waits on a data-memory ready handshake, with an optional timeout.
- Flags unsupported opcodes and bus timeouts.

Parameters:
- MEM_TIMEOUT, 16: maximum number of wait cycles in MEMREAD/MEMWRITE with mem_ready low; 0 disables the timeout.

Ports:
- clk  in  1  clock
- s_rst  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  data memory has completed the current read/write
- pc_write  out  1  load PC from the result bus
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut register
- ir_write  out  1  load the instruction register and old_pc
- mem_write  out  1  data memory write enable
- reg_write  out  1  register bank write enable
- result_src  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = old_pc, 10 = rs1
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- retire  out  1  one-cycle pulse on the last cycle of each completed instruction
- illegal  out  1  sticky: unsupported opcode or funct decoded
- bus_err  out  1  sticky: memory timeout

Behaviour:
- State register only; all outputs are decoded combinationally from state, opcode, funct3, funct7b5 and zero.
- Any output not listed for a state is 0.
- Reset: while s_rst is high, every output is 0. Next state is FETCH; illegal and bus_err clear; timeout counter clears.
- Reset mid-instruction abandons it with no partial writes after the reset edge.
- Supported opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - beq 1100011
  - jal 1101111
- ALU decode for R-type and I-ALU:
  - funct3 000: sub when R-type and funct7b5 = 1, else add
  - funct3 010: slt
  - funct3 110: or
  - funct3 111: and
  - any other funct3: illegal
- States:
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, add, result_src=10, pc_write=1. Next: DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, imm_src=10, add (precomputes branch target). Next: MEMADR for lw/sw, EXECUTER for R-type, EXECUTEI for I-ALU, BEQ, JAL; any other opcode, or bad funct3 on R-type/I-ALU, goes to TRAP.
  - MEMADR: alu_src_a=10, alu_src_b=01, add, imm_src=00 for lw / 01 for sw. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: adr_src=1, result_src=00. Holds while mem_ready=0; goes to MEMWB when mem_ready=1.
  - MEMWB: result_src=01, reg_write=1, retire=1. Next: FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1 held every cycle. Goes to FETCH with retire=1 in the cycle mem_ready=1.
  - EXECUTER: alu_src_a=10, alu_src_b=00, ALU decode. Next: ALUWB.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, imm_src=00, ALU decode. Next: ALUWB.
  - ALUWB: result_src=00, reg_write=1, retire=1. Next: FETCH.
  - BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero, retire=1. Next: FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. Next: ALUWB (rd = old_pc + 4).
  - TRAP: all enables 0. illegal=1 if entered from DECODE; bus_err=1 if entered on timeout. Stays until s_rst.
- Timeout:
  - The counter clears on entry to MEMREAD/MEMWRITE and increments each cycle mem_ready=0.
  - When the counter equals MEM_TIMEOUT with mem_ready=0, next state is TRAP and bus_err is set.
  - If mem_ready=1 in that same cycle, mem_ready wins and the normal transition is taken.
  - MEM_TIMEOUT=0 waits forever.
- CPI:
  - 3 cycles: beq
  - 4 cycles: R-type, I-ALU, jal, sw with mem_ready=1
  - 5 cycles: lw with mem_ready=1
  - Each wait cycle adds 1.

Test Plan:
- Reset, then release with opcode=0110011, funct3=000, funct7b5=1 -> FETCH, DECODE, EXECUTER (alu_control=001), ALUWB with reg_write=1 and retire=1; 4 cycles.
- lw with mem_ready low for 3 cycles then high -> MEMREAD held 4 cycles, adr_src=1 throughout; MEMWB result_src=01; total 8 cycles.
- beq with zero=1 and zero=0 -> pc_write=1 / 0 in BEQ; retire in cycle 3 both times.
- jal -> JAL cycle pc_write=1, then ALUWB reg_write=1; no mem_write in any cycle.
- sw with MEM_TIMEOUT=4 and mem_ready stuck low -> mem_write held 4 cycles, then TRAP with bus_err=1 and all enables 0 until s_rst. Repeat with mem_ready rising exactly at count 4 -> FETCH, no bus_err.
- opcode=1110011 -> TRAP from DECODE with illegal=1. Assert s_rst mid-MEMWRITE -> mem_write=0 immediately after the reset edge, FETCH after release, flags cleared.
